// File: rtl/branch_resolve.sv
// EX-stage branch resolution: carries IF predictions down to EX, detects
// mispredicts, drives flush/redirect and the registered predictor training bus.
module branch_resolve #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rstn,
    input  logic                  if_valid,
    input  logic                  predict_taken,
    input  logic                  predict1_taken,
    input  logic                  predict3_taken,
    input  logic                  is_loop,
    input  logic [ADDR_WIDTH-1:0] predict_target_pc,
    input  logic                  adv_dec,
    input  logic                  adv_ex,
    input  logic                  ex_fire,
    input  logic                  ex_is_branch,
    input  logic                  ex_is_jal,
    input  logic                  ex_is_jalr,
    input  logic                  ex_cond_true,
    input  logic [ADDR_WIDTH-1:0] ex_pc,
    input  logic [ADDR_WIDTH-1:0] ex_target_pc,
    output logic                  flush,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  branch_ex,
    output logic                  jalr_ex,
    output logic                  branch_taken_ex,
    output logic [ADDR_WIDTH-1:0] branch_pc_ex,
    output logic [ADDR_WIDTH-1:0] branch_target_pc,
    output logic                  predict1_taken_ex,
    output logic                  predict3_taken_ex,
    output logic                  is_loop_ex,
    output logic [CNT_WIDTH-1:0]  branch_cnt,
    output logic [CNT_WIDTH-1:0]  mispredict_cnt
);

    typedef struct packed {
        logic                  valid;
        logic                  taken;
        logic                  p1;
        logic                  p3;
        logic                  loop;
        logic [ADDR_WIDTH-1:0] target;
    } carry_t;

    carry_t dec_q, dec_d, ex_q, ex_d;

    logic                  res, actual_taken, mispredict;
    logic [ADDR_WIDTH-1:0] fall;

    logic                  flush_q, flush_d;
    logic [ADDR_WIDTH-1:0] redirect_q, redirect_d;
    logic                  branch_ex_q, branch_ex_d;
    logic                  jalr_ex_q, jalr_ex_d;
    logic                  taken_q, taken_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] tgt_q, tgt_d;
    logic                  p1_q, p1_d, p3_q, p3_d, loop_q, loop_d;
    logic [CNT_WIDTH-1:0]  bcnt_q, bcnt_d, mcnt_q, mcnt_d;

    always_comb begin
        res          = ex_fire && ex_q.valid && (ex_is_branch || ex_is_jal || ex_is_jalr);
        actual_taken = ex_is_branch ? ex_cond_true : 1'b1;
        fall         = ex_pc + ADDR_WIDTH'(4);
        mispredict   = res && ((ex_q.taken != actual_taken) ||
                               (actual_taken && (ex_q.target != ex_target_pc)));
    end

    always_comb begin
        dec_d = dec_q;
        ex_d  = ex_q;
        if (adv_ex) ex_d = dec_q;
        if (adv_dec) begin
            dec_d = '{valid: if_valid, taken: predict_taken, p1: predict1_taken,
                      p3: predict3_taken, loop: is_loop, target: predict_target_pc};
        end else if (adv_ex) begin
            dec_d.valid = 1'b0;
        end
        // Younger predictions are stale once a mispredict resolves; wins over any load.
        if (mispredict) begin
            dec_d.valid = 1'b0;
            ex_d.valid  = 1'b0;
        end
    end

    always_comb begin
        flush_d     = mispredict;
        redirect_d  = redirect_q;
        branch_ex_d = res && ex_is_branch;
        jalr_ex_d   = res && ex_is_jalr;
        taken_d     = taken_q;
        pc_d        = pc_q;
        tgt_d       = tgt_q;
        p1_d        = p1_q;
        p3_d        = p3_q;
        loop_d      = loop_q;
        bcnt_d      = bcnt_q;
        mcnt_d      = mcnt_q;
        if (mispredict) redirect_d = actual_taken ? ex_target_pc : fall;
        if (res) begin
            taken_d = actual_taken;
            pc_d    = ex_pc;
            tgt_d   = ex_target_pc;
            p1_d    = ex_q.p1;
            p3_d    = ex_q.p3;
            loop_d  = ex_q.loop;
            if (bcnt_q != '1) bcnt_d = bcnt_q + CNT_WIDTH'(1);
            if (mispredict && (mcnt_q != '1)) mcnt_d = mcnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            dec_q       <= '0;
            ex_q        <= '0;
            flush_q     <= 1'b0;
            redirect_q  <= '0;
            branch_ex_q <= 1'b0;
            jalr_ex_q   <= 1'b0;
            taken_q     <= 1'b0;
            pc_q        <= '0;
            tgt_q       <= '0;
            p1_q        <= 1'b0;
            p3_q        <= 1'b0;
            loop_q      <= 1'b0;
            bcnt_q      <= '0;
            mcnt_q      <= '0;
        end else begin
            dec_q       <= dec_d;
            ex_q        <= ex_d;
            flush_q     <= flush_d;
            redirect_q  <= redirect_d;
            branch_ex_q <= branch_ex_d;
            jalr_ex_q   <= jalr_ex_d;
            taken_q     <= taken_d;
            pc_q        <= pc_d;
            tgt_q       <= tgt_d;
            p1_q        <= p1_d;
            p3_q        <= p3_d;
            loop_q      <= loop_d;
            bcnt_q      <= bcnt_d;
            mcnt_q      <= mcnt_d;
        end
    end

    assign flush             = flush_q;
    assign redirect_pc       = redirect_q;
    assign branch_ex         = branch_ex_q;
    assign jalr_ex           = jalr_ex_q;
    assign branch_taken_ex   = taken_q;
    assign branch_pc_ex      = pc_q;
    assign branch_target_pc  = tgt_q;
    assign predict1_taken_ex = p1_q;
    assign predict3_taken_ex = p3_q;
    assign is_loop_ex        = loop_q;
    assign branch_cnt        = bcnt_q;
    assign mispredict_cnt    = mcnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: a cycle model pushes expected outputs,
// each scenario task drains and compares them against sampled DUT outputs.
module tb_branch_resolve;

    logic        cpu_clk = 1'b0;
    logic        cpu_rstn;
    logic        if_valid, predict_taken, predict1_taken, predict3_taken, is_loop;
    logic [31:0] predict_target_pc;
    logic        adv_dec, adv_ex, ex_fire, ex_is_branch, ex_is_jal, ex_is_jalr, ex_cond_true;
    logic [31:0] ex_pc, ex_target_pc;
    logic        flush, branch_ex, jalr_ex, branch_taken_ex;
    logic [31:0] redirect_pc, branch_pc_ex, branch_target_pc;
    logic        predict1_taken_ex, predict3_taken_ex, is_loop_ex;
    logic [3:0]  branch_cnt, mispredict_cnt;

    branch_resolve #(.ADDR_WIDTH(32), .CNT_WIDTH(4)) dut (
        .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn),
        .if_valid(if_valid), .predict_taken(predict_taken),
        .predict1_taken(predict1_taken), .predict3_taken(predict3_taken),
        .is_loop(is_loop), .predict_target_pc(predict_target_pc),
        .adv_dec(adv_dec), .adv_ex(adv_ex), .ex_fire(ex_fire),
        .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
        .ex_cond_true(ex_cond_true), .ex_pc(ex_pc), .ex_target_pc(ex_target_pc),
        .flush(flush), .redirect_pc(redirect_pc), .branch_ex(branch_ex),
        .jalr_ex(jalr_ex), .branch_taken_ex(branch_taken_ex),
        .branch_pc_ex(branch_pc_ex), .branch_target_pc(branch_target_pc),
        .predict1_taken_ex(predict1_taken_ex), .predict3_taken_ex(predict3_taken_ex),
        .is_loop_ex(is_loop_ex), .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct packed {
        logic        flush;
        logic [31:0] redir;
        logic        bex, jex, tk;
        logic [31:0] pc, tgt;
        logic        p1, p3, lp;
        logic [3:0]  bc, mc;
    } obs_t;

    typedef struct packed {
        logic        v, t, p1, p3, lp;
        logic [31:0] tgt;
    } slot_t;

    obs_t  exp_q[$];
    obs_t  got_q[$];
    obs_t  m_out;
    slot_t m_dec, m_ex;
    int    passed = 0;
    int    total  = 0;

    function automatic obs_t sample();
        obs_t s;
        s = {flush, redirect_pc, branch_ex, jalr_ex, branch_taken_ex, branch_pc_ex,
             branch_target_pc, predict1_taken_ex, predict3_taken_ex, is_loop_ex,
             branch_cnt, mispredict_cnt};
        return s;
    endfunction

    task automatic idle_inputs();
        if_valid = 0; predict_taken = 0; predict1_taken = 0; predict3_taken = 0;
        is_loop = 0; predict_target_pc = '0; adv_dec = 0; adv_ex = 0; ex_fire = 0;
        ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0; ex_cond_true = 0;
        ex_pc = '0; ex_target_pc = '0;
    endtask

    task automatic model_reset();
        m_out = '0; m_dec = '0; m_ex = '0;
    endtask

    // One clock with the currently driven inputs; model expected and sample actual.
    task automatic step();
        obs_t  e;
        slot_t nd, ne;
        logic  res, tk, wrong;
        e     = m_out;
        res   = ex_fire && m_ex.v && (ex_is_branch || ex_is_jal || ex_is_jalr);
        tk    = ex_is_branch ? ex_cond_true : 1'b1;
        wrong = res && ((m_ex.t != tk) || (tk && (m_ex.tgt != ex_target_pc)));
        e.flush = wrong;
        e.bex   = res && ex_is_branch;
        e.jex   = res && ex_is_jalr;
        if (wrong) e.redir = tk ? ex_target_pc : (ex_pc + 32'd4);
        if (res) begin
            e.tk = tk; e.pc = ex_pc; e.tgt = ex_target_pc;
            e.p1 = m_ex.p1; e.p3 = m_ex.p3; e.lp = m_ex.lp;
            if (e.bc != 4'hF) e.bc = e.bc + 4'd1;
            if (wrong && e.mc != 4'hF) e.mc = e.mc + 4'd1;
        end
        ne = adv_ex ? m_dec : m_ex;
        nd = m_dec;
        if (adv_dec) nd = '{if_valid, predict_taken, predict1_taken, predict3_taken,
                            is_loop, predict_target_pc};
        else if (adv_ex) nd.v = 1'b0;
        if (wrong) begin nd.v = 1'b0; ne.v = 1'b0; end
        @(posedge cpu_clk);
        @(negedge cpu_clk);
        m_dec = nd; m_ex = ne; m_out = e;
        exp_q.push_back(e);
        got_q.push_back(sample());
    endtask

    task automatic issue(input logic pt, input logic p1, input logic p3,
                         input logic lp, input logic [31:0] ptgt);
        idle_inputs();
        if_valid = 1; predict_taken = pt; predict1_taken = p1; predict3_taken = p3;
        is_loop = lp; predict_target_pc = ptgt; adv_dec = 1;
        step();
        idle_inputs();
        adv_ex = 1;
        step();
        idle_inputs();
    endtask

    task automatic resolve(input logic b, input logic j, input logic jr, input logic cond,
                           input logic [31:0] pc, input logic [31:0] tgt);
        idle_inputs();
        ex_fire = 1; ex_is_branch = b; ex_is_jal = j; ex_is_jalr = jr;
        ex_cond_true = cond; ex_pc = pc; ex_target_pc = tgt;
        step();
        idle_inputs();
    endtask

    task automatic test_reset();
        obs_t e, g;
        idle_inputs();
        cpu_rstn = 0;
        model_reset();
        @(negedge cpu_clk);
        @(negedge cpu_clk);
        g = sample();
        total++;
        if (g !== '0) $display("FAIL reset_state: got %h expected 0", g);
        else passed++;
        cpu_rstn = 1;
        step();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); total++;
            if (g !== e) $display("FAIL reset_idle: got %h expected %h", g, e);
            else passed++;
        end
    endtask

    task automatic test_correct_not_taken();
        obs_t e, g;
        issue(0, 1, 0, 0, 32'h0000_0180);
        resolve(1, 0, 0, 0, 32'h0000_0100, 32'h0000_0180);
        step();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); total++;
            if (g !== e) $display("FAIL correct_not_taken: got %h expected %h", g, e);
            else passed++;
        end
    endtask

    task automatic test_wrong_direction();
        obs_t e, g;
        issue(0, 0, 1, 0, 32'h0000_0000);
        resolve(1, 0, 0, 1, 32'h0000_0200, 32'h0000_0180);
        resolve(1, 0, 0, 1, 32'h0000_0204, 32'h0000_0300);
        total++;
        if (branch_ex !== 1'b0) $display("FAIL fire_after_flush: got branch_ex=%b expected 0", branch_ex);
        else passed++;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); total++;
            if (g !== e) $display("FAIL wrong_direction: got %h expected %h", g, e);
            else passed++;
        end
    endtask

    task automatic test_wrong_target();
        obs_t e, g;
        issue(1, 1, 1, 0, 32'h0000_0400);
        resolve(0, 0, 1, 0, 32'h0000_0300, 32'h0000_0440);
        step();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); total++;
            if (g !== e) $display("FAIL wrong_target: got %h expected %h", g, e);
            else passed++;
        end
    endtask

    task automatic test_wrap_and_nt_target();
        obs_t e, g;
        issue(1, 0, 0, 1, 32'h0000_0040);
        resolve(1, 0, 0, 0, 32'hFFFF_FFFC, 32'h0000_0040);
        total++;
        if (redirect_pc !== 32'h0000_0000 || flush !== 1'b1)
            $display("FAIL wrap_redirect: got flush=%b pc=%h expected 1/00000000", flush, redirect_pc);
        else passed++;
        // predicted not-taken and not taken with a different target: no flush
        issue(0, 0, 0, 0, 32'h0000_1234);
        resolve(1, 0, 0, 0, 32'h0000_0500, 32'h0000_5678);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); total++;
            if (g !== e) $display("FAIL wrap_nt_target: got %h expected %h", g, e);
            else passed++;
        end
    endtask

    task automatic test_stall_back_to_back();
        obs_t e, g;
        idle_inputs();
        if_valid = 1; predict_taken = 0; predict1_taken = 1; predict3_taken = 0;
        is_loop = 1; predict_target_pc = 32'h0000_0111; adv_dec = 1;
        step();
        predict_taken = 1; predict1_taken = 0; predict3_taken = 1; is_loop = 0;
        predict_target_pc = 32'h0000_0800; adv_ex = 1;
        step();
        adv_dec = 0; adv_ex = 0;
        predict_taken = 1; predict1_taken = 1; predict3_taken = 1; is_loop = 1;
        predict_target_pc = 32'hDEAD_0000;
        for (int i = 0; i < 3; i++) step();
        idle_inputs();
        ex_fire = 1; ex_is_branch = 1; ex_cond_true = 0; ex_pc = 32'h0000_0A00;
        ex_target_pc = 32'h0000_0111; adv_ex = 1;
        step();
        total++;
        if ({predict1_taken_ex, predict3_taken_ex, is_loop_ex} !== 3'b101)
            $display("FAIL stall_votes_A: got %b expected 101",
                     {predict1_taken_ex, predict3_taken_ex, is_loop_ex});
        else passed++;
        idle_inputs();
        ex_fire = 1; ex_is_jal = 1; ex_pc = 32'h0000_0A04; ex_target_pc = 32'h0000_0800;
        step();
        idle_inputs();
        step();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); total++;
            if (g !== e) $display("FAIL stall_back_to_back: got %h expected %h", g, e);
            else passed++;
        end
    endtask

    task automatic test_saturation_and_async_reset();
        obs_t e, g;
        for (int i = 0; i < 20; i++) begin
            issue(0, 0, 0, 0, 32'h0);
            resolve(1, 0, 0, 1, 32'h0000_1000 + 32'(i * 8), 32'h0000_2000);
        end
        total++;
        if (branch_cnt !== 4'hF || mispredict_cnt !== 4'hF)
            $display("FAIL saturation: got bc=%h mc=%h expected F/F", branch_cnt, mispredict_cnt);
        else passed++;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); total++;
            if (g !== e) $display("FAIL saturation_seq: got %h expected %h", g, e);
            else passed++;
        end
        // flush is high here; async reset between edges must clear it at once
        #1 cpu_rstn = 0;
        #1;
        g = sample();
        total++;
        if (g !== '0) $display("FAIL async_reset: got %h expected 0", g);
        else passed++;
        model_reset();
        @(negedge cpu_clk);
        cpu_rstn = 1;
    endtask

    initial begin
        test_reset();
        test_correct_not_taken();
        test_wrong_direction();
        test_wrong_target();
        test_wrap_and_nt_target();
        test_stall_back_to_back();
        test_saturation_and_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
